hms_preset_seq: RTL and testbench

Command sequencer that drives the preset and control port of the hours/minutes/seconds timekeeper (`load`/`din`/`addr`/`ss`). It accepts a target time over a req/ack handshake and range-checks it. It then stops the timekeeper if it is running, writes hours, minutes and seconds, and optionally restarts it. It sits between the host/keypad logic and the timekeeper wrapper, replacing hand-sequenced pulse generation.

---
 rtl/hms_pkg.sv | 27 ++
 rtl/hms_range_chk.sv | 16 +
 rtl/hms_preset_seq.sv | 198 +++++++++++++++++++
 tb/tb_hms_preset_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// rtl/hms_pkg.sv - shared states, addresses and limits for the hms timekeeper control path
package hms_pkg;

    // Sequencer states; ST_GAP is the shared idle-spacing state between command pulses
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_STOP  = 4'd1,
        ST_WR_H  = 4'd2,
        ST_WR_M  = 4'd3,
        ST_WR_S  = 4'd4,
        ST_CHK   = 4'd5,
        ST_START = 4'd6,
        ST_FIN   = 4'd7,
        ST_GAP   = 4'd8
    } hms_seq_state_t;

    // Timekeeper preset port addresses
    localparam logic [1:0] HMS_ADDR_HRS = 2'd3;
    localparam logic [1:0] HMS_ADDR_MIN = 2'd2;
    localparam logic [1:0] HMS_ADDR_SEC = 2'd1;
    localparam logic [1:0] HMS_ADDR_NONE = 2'd0;

    // Largest legal field values
    localparam logic [4:0] HMS_MAX_HRS     = 5'd23;
    localparam logic [5:0] HMS_MAX_MIN_SEC = 6'd59;

endpackage

// File: rtl/hms_range_chk.sv
// rtl/hms_range_chk.sv - combinational validity check of an hours/minutes/seconds triple
module hms_range_chk
    import hms_pkg::*;
(
    input  logic [4:0] hrs,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic       valid
);

    // A triple is usable only when every field is inside its clock range
    assign valid = (hrs <= HMS_MAX_HRS)
                && (min <= HMS_MAX_MIN_SEC)
                && (sec <= HMS_MAX_MIN_SEC);

endmodule

// File: rtl/hms_preset_seq.sv
// rtl/hms_preset_seq.sv - preset command sequencer for the hms timekeeper (optional readback check: HMS_PRESET_VERIFY_EN)
module hms_preset_seq
    import hms_pkg::*;
#(
    parameter int unsigned RUN_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [4:0] t_hrs,
    input  logic [5:0] t_min,
    input  logic [5:0] t_sec,
    input  logic       run_after,
    input  logic       clk_running,
    input  logic [4:0] hrs,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss,
    output logic       load,
    output logic [1:0] addr,
    output logic [5:0] din
);

    localparam int unsigned GAP_W = (RUN_GAP < 2) ? 1 : $clog2(RUN_GAP + 1);

    hms_seq_state_t   state;
    hms_seq_state_t   gap_next;   // state to resume once the gap has elapsed
    logic [GAP_W-1:0] gap_cnt;

    logic [4:0]       lat_hrs;
    logic [5:0]       lat_min;
    logic [5:0]       lat_sec;
    logic             lat_run;
    logic             rej_q;      // FIN reports err instead of done
    logic             in_valid;

`ifdef HMS_PRESET_VERIFY_EN
    logic             retry_q;    // one rewrite pass already spent
    logic             rb_match;

    assign rb_match = (hrs == lat_hrs) && (min == lat_min) && (sec == lat_sec);
`else
    // Readback only matters to the check state, which this build leaves out
    logic             unused_readback;

    assign unused_readback = ^{hrs, min, sec};
`endif

    hms_range_chk u_range_chk (
        .hrs   (t_hrs),
        .min   (t_min),
        .sec   (t_sec),
        .valid (in_valid)
    );

    // Sequencer: accept, stop, write H/M/S, optional check and restart, report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gap_next <= ST_IDLE;
            gap_cnt  <= '0;
            lat_hrs  <= '0;
            lat_min  <= '0;
            lat_sec  <= '0;
            lat_run  <= 1'b0;
            rej_q    <= 1'b0;
`ifdef HMS_PRESET_VERIFY_EN
            retry_q  <= 1'b0;
`endif
            ack      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ss       <= 1'b0;
            load     <= 1'b0;
            addr     <= HMS_ADDR_NONE;
            din      <= '0;
        end else begin
            // Every strobe is a single-cycle pulse; address and data idle at zero
            ack  <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            ss   <= 1'b0;
            load <= 1'b0;
            addr <= HMS_ADDR_NONE;
            din  <= '0;

            case (state)
                ST_IDLE: begin
                    // busy is still high for one cycle after done/err; req is ignored then
                    busy <= 1'b0;
                    if (req && !busy) begin
                        ack     <= 1'b1;
                        lat_hrs <= t_hrs;
                        lat_min <= t_min;
                        lat_sec <= t_sec;
                        lat_run <= run_after;
`ifdef HMS_PRESET_VERIFY_EN
                        retry_q <= 1'b0;
`endif
                        if (in_valid) begin
                            busy  <= 1'b1;
                            rej_q <= 1'b0;
                            state <= clk_running ? ST_STOP : ST_WR_H;
                        end else begin
                            rej_q <= 1'b1;
                            state <= ST_FIN;
                        end
                    end
                end

                ST_STOP: begin
                    ss       <= 1'b1;
                    gap_cnt  <= GAP_W'(RUN_GAP);
                    gap_next <= ST_WR_H;
                    state    <= ST_GAP;
                end

                ST_WR_H: begin
                    load     <= 1'b1;
                    addr     <= HMS_ADDR_HRS;
                    din      <= {1'b0, lat_hrs};
                    gap_cnt  <= GAP_W'(RUN_GAP);
                    gap_next <= ST_WR_M;
                    state    <= ST_GAP;
                end

                ST_WR_M: begin
                    load     <= 1'b1;
                    addr     <= HMS_ADDR_MIN;
                    din      <= lat_min;
                    gap_cnt  <= GAP_W'(RUN_GAP);
                    gap_next <= ST_WR_S;
                    state    <= ST_GAP;
                end

                ST_WR_S: begin
                    load     <= 1'b1;
                    addr     <= HMS_ADDR_SEC;
                    din      <= lat_sec;
                    gap_cnt  <= GAP_W'(RUN_GAP);
`ifdef HMS_PRESET_VERIFY_EN
                    gap_next <= ST_CHK;
`else
                    gap_next <= lat_run ? ST_START : ST_FIN;
`endif
                    state    <= ST_GAP;
                end

`ifdef HMS_PRESET_VERIFY_EN
                ST_CHK: begin
                    // One rewrite is allowed; a second mismatch ends in err without restart
                    if (rb_match) begin
                        state <= lat_run ? ST_START : ST_FIN;
                    end else if (!retry_q) begin
                        retry_q <= 1'b1;
                        state   <= ST_WR_H;
                    end else begin
                        rej_q <= 1'b1;
                        state <= ST_FIN;
                    end
                end
`endif

                ST_START: begin
                    ss       <= 1'b1;
                    gap_cnt  <= GAP_W'(RUN_GAP);
                    gap_next <= ST_FIN;
                    state    <= ST_GAP;
                end

                ST_FIN: begin
                    done  <= ~rej_q;
                    err   <= rej_q;
                    rej_q <= 1'b0;
                    state <= ST_IDLE;
                end

                ST_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= gap_next;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hms_preset_seq.sv
// tb/tb_hms_preset_seq.sv - scoreboard bench for hms_preset_seq
`timescale 1ns/1ps
module tb_hms_preset_seq;

    localparam int G = 1;
    localparam int P = G + 1;

    localparam int K_ACK  = 0;
    localparam int K_SS   = 1;
    localparam int K_LOAD = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int kind;
        int rel;       // cycles after the owning ack; for an ack, after the previous ack (-1: free)
        int addr;
        int data;
        int busy_end;  // acks only: last cycle busy is high, -1 when busy must stay low
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [4:0] t_hrs = '0;
    logic [5:0] t_min = '0;
    logic [5:0] t_sec = '0;
    logic       run_after = 1'b0;
    logic       clk_running = 1'b0;
    logic [4:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
    logic       ack, busy, done, err, ss, load;
    logic [1:0] addr;
    logic [5:0] din;

    logic [4:0] tk_h = '0;
    logic [5:0] tk_m = '0;
    logic [5:0] tk_s = '0;
    logic       force_zero = 1'b0;

    int  cyc = 0;
    int  base = 0;
    bit  base_valid = 1'b0;
    int  busy_end_abs = -1;
    bit  busy_exp;
    int  n_checks = 0;
    int  n_fail = 0;
    ev_t exp_q[$];

    hms_preset_seq #(.RUN_GAP(G)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .t_hrs       (t_hrs),
        .t_min       (t_min),
        .t_sec       (t_sec),
        .run_after   (run_after),
        .clk_running (clk_running),
        .hrs         (hrs),
        .min         (min),
        .sec         (sec),
        .ack         (ack),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ss          (ss),
        .load        (load),
        .addr        (addr),
        .din         (din)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Minimal timekeeper register file so readback reflects the writes
    always @(posedge clk) begin
        if (load) begin
            case (addr)
                2'd3: tk_h <= din[4:0];
                2'd2: tk_m <= din;
                2'd1: tk_s <= din;
                default: ;
            endcase
        end
    end

    assign hrs = force_zero ? 5'd0 : tk_h;
    assign min = force_zero ? 6'd0 : tk_m;
    assign sec = force_zero ? 6'd0 : tk_s;

    function automatic string kname(input int k);
        case (k)
            K_ACK:  return "ack";
            K_SS:   return "ss";
            K_LOAD: return "load";
            K_DONE: return "done";
            default: return "err";
        endcase
    endfunction

    // Reference: expected pulse schedule derived from the sequencing rules
    task automatic model_req(input int h, input int m, input int s, input bit ra, input bit cr,
                             input int ack_rel, output int end_rel);
        ev_t seq[$];
        int  t;
`ifdef HMS_PRESET_VERIFY_EN
        bit  match;
`endif
        end_rel = -1;
        if (h > 23 || m > 59 || s > 59) begin
            exp_q.push_back('{K_ACK, ack_rel, 0, 0, -1});
            exp_q.push_back('{K_ERR, 1, 0, 0, 0});
            return;
        end
        t = 1;
        if (cr) begin
            seq.push_back('{K_SS, t, 0, 0, 0});
            t += P;
        end
        seq.push_back('{K_LOAD, t,       3, h, 0});
        seq.push_back('{K_LOAD, t + P,   2, m, 0});
        seq.push_back('{K_LOAD, t + 2*P, 1, s, 0});
        t += 3 * P;
`ifdef HMS_PRESET_VERIFY_EN
        match = !force_zero || (h == 0 && m == 0 && s == 0);
        t += 1;
        if (!match) begin
            seq.push_back('{K_LOAD, t,       3, h, 0});
            seq.push_back('{K_LOAD, t + P,   2, m, 0});
            seq.push_back('{K_LOAD, t + 2*P, 1, s, 0});
            t += 3 * P + 1;
            seq.push_back('{K_ERR, t, 0, 0, 0});
            end_rel = t;
        end
`endif
        if (end_rel < 0) begin
            if (ra) begin
                seq.push_back('{K_SS, t, 0, 0, 0});
                t += P;
            end
            seq.push_back('{K_DONE, t, 0, 0, 0});
            end_rel = t;
        end
        exp_q.push_back('{K_ACK, ack_rel, 0, 0, end_rel});
        foreach (seq[i]) exp_q.push_back(seq[i]);
    endtask

    // Pop the next expectation for a pulse the DUT presented this cycle
    task automatic take(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got pulse at cycle %0d, required none", kname(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (kind == K_ACK) begin
            if (e.kind != K_ACK || (e.rel >= 0 && cyc != base + e.rel)) begin
                n_fail++;
                $display("FAIL ack: got ack at cycle %0d, required %s at cycle %0d",
                         cyc, kname(e.kind), base + e.rel);
            end
            base = cyc;
            base_valid = 1'b1;
            busy_end_abs = (e.busy_end < 0) ? -1 : cyc + e.busy_end;
        end else if (e.kind != kind || cyc != base + e.rel ||
                     (kind == K_LOAD && (int'(addr) != e.addr || int'(din) != e.data))) begin
            n_fail++;
            $display("FAIL %s: got %s addr=%0d din=%0d at rel %0d, required %s addr=%0d din=%0d at rel %0d",
                     kname(kind), kname(kind), addr, din, cyc - base,
                     kname(e.kind), e.addr, e.data, e.rel);
        end
    endtask

    // Monitor: compares every presented pulse and the busy window against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            n_checks++;
            if ({ack, busy, done, err, ss, load, addr, din} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got ack=%b busy=%b done=%b err=%b ss=%b load=%b addr=%0d din=%0d, required all 0",
                         ack, busy, done, err, ss, load, addr, din);
            end
            exp_q.delete();
            base_valid = 1'b0;
            busy_end_abs = -1;
        end else begin
            if (ack)  take(K_ACK);
            if (ss)   take(K_SS);
            if (load) take(K_LOAD);
            if (done) take(K_DONE);
            if (err)  take(K_ERR);
            busy_exp = base_valid && busy_end_abs >= 0 && cyc >= base && cyc <= busy_end_abs;
            n_checks++;
            if (busy !== busy_exp) begin
                n_fail++;
                $display("FAIL busy: got %b at rel %0d, required %b", busy, cyc - base, busy_exp);
            end
            if (!load) begin
                n_checks++;
                if (addr !== 2'd0 || din !== 6'd0) begin
                    n_fail++;
                    $display("FAIL idle_bus: got addr=%0d din=%0d, required 0 0", addr, din);
                end
            end
            if (exp_q.size() > 0 && base_valid && exp_q[0].rel >= 0 && base + exp_q[0].rel <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_%s: got nothing by rel %0d, required at rel %0d",
                         kname(exp_q[0].kind), cyc - base, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_ack(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = ack;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no ack in 100 cycles, required ack", nm);
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && !busy;
        end
        n_checks++;
        if (!idle) begin
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending events busy=%b, required 0 and 0", exp_q.size(), busy);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic scramble();
        t_hrs       = 5'($urandom);
        t_min       = 6'($urandom);
        t_sec       = 6'($urandom);
        run_after   = 1'($urandom);
        clk_running = 1'($urandom);
    endtask

    task automatic do_req(input int h, input int m, input int s, input bit ra, input bit cr, input bit hold);
        int end_rel;
        int unused_rel;
        t_hrs       = 5'(h);
        t_min       = 6'(m);
        t_sec       = 6'(s);
        run_after   = ra;
        clk_running = cr;
        model_req(h, m, s, ra, cr, -1, end_rel);
        if (hold) model_req(h, m, s, ra, cr, end_rel + 2, unused_rel);
        req = 1'b1;
        wait_ack("ack_timeout");
        if (hold) wait_ack("second_ack_timeout");
        req = 1'b0;
        scramble();
        wait_idle();
    endtask

    task automatic reset_mid();
        int  unused_rel;
        bit  seen = 1'b0;
        t_hrs = 5'd9; t_min = 6'd45; t_sec = 6'd30;
        run_after = 1'b1; clk_running = 1'b1;
        model_req(9, 45, 30, 1'b1, 1'b1, -1, unused_rel);
        req = 1'b1;
        wait_ack("rst_ack_timeout");
        req = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = load && (addr == 2'd2);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_wr_m: got no minutes write, required one");
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ack, busy, done, err, ss, load, addr, din} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b ss=%b load=%b addr=%0d din=%0d, required all 0",
                     busy, ss, load, addr, din);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, m, s;
        bit valid;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_req(23, 59, 55, 1'b1, 1'b0, 1'b0);
        do_req(12, 0, 0, 1'b0, 1'b1, 1'b0);
        do_req(24, 0, 0, 1'b1, 1'b1, 1'b0);
        do_req(10, 60, 0, 1'b0, 1'b0, 1'b0);
        do_req(0, 0, 60, 1'b1, 1'b0, 1'b0);
        do_req(0, 0, 0, 1'b1, 1'b1, 1'b0);
        do_req(7, 30, 15, 1'b1, 1'b1, 1'b1);
        reset_mid();
        do_req(9, 45, 30, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            s = $urandom_range(0, 59);
            valid = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                valid = 1'b0;
                case ($urandom_range(0, 2))
                    0: h = $urandom_range(24, 31);
                    1: m = $urandom_range(60, 63);
                    default: s = $urandom_range(60, 63);
                endcase
            end
            do_req(h, m, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   valid && ($urandom_range(0, 5) == 0));
        end

`ifdef HMS_PRESET_VERIFY_EN
        force_zero = 1'b1;
        do_req(5, 6, 7, 1'b1, 1'b1, 1'b0);
        force_zero = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
